// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the EX-stage ALU with iterative multiply/divide.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package alu_muldiv_pkg;

  // Opcode set: original single-cycle ops followed by the multiply/divide extensions.
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SLA  = 5'd7,
    ALU_SRA  = 5'd8,
    ALU_LUI  = 5'd9,
    ALU_LLI  = 5'd10,
    ALU_NOT  = 5'd11,
    ALU_MUL  = 5'd12,
    ALU_MULU = 5'd13,
    ALU_DIV  = 5'd14,
    ALU_DIVU = 5'd15,
    ALU_MFHI = 5'd16,
    ALU_MFLO = 5'd17
  } operation_t;

  // Sequencing states for the registered ALU.
  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIV  = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_t;

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative radix-2 shift-add multiplier / restoring divider with sign fix-up.
// Latency: DATA_SIZE iteration cycles after start, then one fix cycle.
// Backpressure: none; start is only issued by the parent while idle.
// Ports: start/is_div/is_signed/a/b latch an operation; done marks the last
// iteration edge; fix applies sign/div-by-zero correction; res_hi/res_lo/dz
// hold the corrected result.
module muldiv_core
  import alu_muldiv_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_div,
  input  logic                 is_signed,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  input  logic                 fix,
  output logic                 done,
  output logic [DATA_SIZE-1:0] res_hi,
  output logic [DATA_SIZE-1:0] res_lo,
  output logic                 dz
);
  localparam int W     = DATA_SIZE;
  localparam int CNT_W = $clog2(DATA_SIZE);

  // acc holds {hi, lo}: product accumulator, or {remainder, quotient}.
  logic [2*W-1:0]   acc;
  logic [W-1:0]     mcand;
  logic [W-1:0]     a_raw;
  logic             div_mode;
  logic             neg_q;
  logic             neg_r;
  logic             running;
  logic [CNT_W-1:0] cnt;

  logic             sa;
  logic             sb;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   mul_next;
  logic [W:0]       div_trial;
  logic [2*W-1:0]   div_next;

  assign sa = is_signed & a[W-1];
  assign sb = is_signed & b[W-1];

  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc[W-1:1]};
    // Trial subtract on the shifted partial remainder; a borrow means restore.
    div_trial = acc[2*W-1:W-1] - {1'b0, mcand};
    div_next  = div_trial[W] ? {acc[2*W-2:0], 1'b0}
                             : {div_trial[W-1:0], acc[W-2:0], 1'b1};
  end

  assign done   = running && (cnt == CNT_W'(DATA_SIZE - 1));
  assign res_hi = acc[2*W-1:W];
  assign res_lo = acc[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mcand    <= '0;
      a_raw    <= '0;
      div_mode <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      running  <= 1'b0;
      cnt      <= '0;
      dz       <= 1'b0;
    end else if (start) begin
      acc      <= {{W{1'b0}}, (sa ? -a : a)};
      mcand    <= sb ? -b : b;
      a_raw    <= a;
      div_mode <= is_div;
      neg_q    <= sa ^ sb;
      neg_r    <= sa;
      dz       <= is_div && (b == '0);
      running  <= 1'b1;
      cnt      <= '0;
    end else if (running) begin
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
      // Divide-by-zero keeps counting so latency matches, but the datapath idles.
      if (!dz) acc <= div_mode ? div_next : mul_next;
    end else if (fix) begin
      if (dz)
        acc <= {a_raw, {W{1'b1}}};
      else if (!div_mode)
        acc <= neg_q ? -acc : acc;
      else
        acc <= {(neg_r ? -acc[2*W-1:W] : acc[2*W-1:W]),
                (neg_q ? -acc[W-1:0]   : acc[W-1:0])};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Registered EX-stage ALU: single-cycle ops plus iterative MUL/DIV into HI/LO.
// Latency: 1 cycle for basic ops and MFHI/MFLO, DATA_SIZE+2 for MUL/DIV.
// Backpressure: busy high while MUL/DIV in flight; valid_in is dropped then.
// Ports: valid_in/op/a/b request; busy/valid_out handshake; r/z/n/dz result
// and flags (held between pulses); hi/lo always-visible result registers.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int SHAMT_W   = $clog2(DATA_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  operation_t           op,
  input  logic [DATA_SIZE-1:0] a,
  input  logic [DATA_SIZE-1:0] b,
  output logic                 busy,
  output logic                 valid_out,
  output logic [DATA_SIZE-1:0] r,
  output logic [DATA_SIZE-1:0] hi,
  output logic [DATA_SIZE-1:0] lo,
  output logic                 z,
  output logic                 n,
  output logic                 dz
);
  localparam int HALF = DATA_SIZE / 2;

  md_state_t            state;
  logic [DATA_SIZE-1:0] basic_res;
  logic [SHAMT_W-1:0]   shamt;
  logic                 is_mul_op;
  logic                 is_div_op;
  logic                 start;
  logic                 core_done;
  logic [DATA_SIZE-1:0] core_hi;
  logic [DATA_SIZE-1:0] core_lo;
  logic                 core_dz;

  assign shamt     = a[SHAMT_W-1:0];
  assign is_mul_op = (op == ALU_MUL) || (op == ALU_MULU);
  assign is_div_op = (op == ALU_DIV) || (op == ALU_DIVU);
  assign start     = (state == MD_IDLE) && valid_in && (is_mul_op || is_div_op);
  assign busy      = (state != MD_IDLE);

  // Shifts move b by the amount in a; LUI/LLI place b's low half.
  always_comb begin
    basic_res = '0;
    case (op)
      ALU_ADD:  basic_res = a + b;
      ALU_SUB:  basic_res = a - b;
      ALU_AND:  basic_res = a & b;
      ALU_OR:   basic_res = a | b;
      ALU_XOR:  basic_res = a ^ b;
      ALU_SLL:  basic_res = b << shamt;
      ALU_SRL:  basic_res = b >> shamt;
      ALU_SLA:  basic_res = b <<< shamt;
      ALU_SRA:  basic_res = $signed(b) >>> shamt;
      ALU_LUI:  basic_res = {b[HALF-1:0], {HALF{1'b0}}};
      ALU_LLI:  basic_res = {{HALF{1'b0}}, b[HALF-1:0]};
      ALU_NOT:  basic_res = ~a;
      ALU_MFHI: basic_res = hi;
      ALU_MFLO: basic_res = lo;
      default:  basic_res = '0;
    endcase
  end

  muldiv_core #(.DATA_SIZE(DATA_SIZE)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_div    (is_div_op),
    .is_signed ((op == ALU_MUL) || (op == ALU_DIV)),
    .a         (a),
    .b         (b),
    .fix       (state == MD_FIX),
    .done      (core_done),
    .res_hi    (core_hi),
    .res_lo    (core_lo),
    .dz        (core_dz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MD_IDLE;
      r         <= '0;
      hi        <= '0;
      lo        <= '0;
      z         <= 1'b0;
      n         <= 1'b0;
      dz        <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (valid_in) begin
            if (is_mul_op) begin
              state <= MD_MUL;
            end else if (is_div_op) begin
              state <= MD_DIV;
            end else begin
              r         <= basic_res;
              z         <= (basic_res == '0);
              n         <= basic_res[DATA_SIZE-1];
              dz        <= 1'b0;
              valid_out <= 1'b1;
            end
          end
        end
        MD_MUL, MD_DIV: if (core_done) state <= MD_FIX;
        MD_FIX:         state <= MD_DONE;
        MD_DONE: begin
          hi        <= core_hi;
          lo        <= core_lo;
          r         <= core_lo;
          z         <= (core_lo == '0);
          n         <= core_lo[DATA_SIZE-1];
          dz        <= core_dz;
          valid_out <= 1'b1;
          state     <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: basic ops, MUL/DIV latency, HI/LO, dz, reset abort.
// Latency: checks 1-cycle basic ops and DATA_SIZE+2 for MUL/DIV.
// Backpressure: checks that valid_in during busy is ignored.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  operation_t  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        valid_out;
  logic [31:0] r;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        z;
  logic        n;
  logic        dz;

  int errors = 0;
  int checks = 0;

  alu_muldiv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .valid_out (valid_out),
    .r         (r),
    .hi        (hi),
    .lo        (lo),
    .z         (z),
    .n         (n),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic issue(input operation_t o, input logic [31:0] av, input logic [31:0] bv);
    op       = o;
    a        = av;
    b        = bv;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  // Counts cycles from the accept edge to valid_out, and busy samples on the way.
  task automatic run_md(output int lat, output int bsy);
    lat = 0;
    bsy = 0;
    while (!valid_out && lat < 100) begin
      if (busy) bsy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  int lat;
  int bsy;
  int pulses;
  logic [31:0] r_seen;

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    op       = ALU_ADD;
    a        = '0;
    b        = '0;
    #1;
    chk("rst_r", r, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_vout", {31'h0, valid_out}, 32'h0);
    chk("rst_flags", {29'h0, z, n, dz}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: ADD
    issue(ALU_ADD, 32'd5, 32'd7);
    chk("add_r", r, 32'd12);
    chk("add_vout", {31'h0, valid_out}, 32'h1);
    chk("add_zn", {30'h0, z, n}, 32'h0);
    chk("add_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;
    chk("add_vout_drop", {31'h0, valid_out}, 32'h0);

    // SUB to zero
    issue(ALU_SUB, 32'd5, 32'd5);
    chk("sub_r", r, 32'h0);
    chk("sub_z", {31'h0, z}, 32'h1);

    // SRA of negative value by 4
    issue(ALU_SRA, 32'd4, 32'h8000_0000);
    chk("sra_r", r, 32'hF800_0000);
    chk("sra_n", {31'h0, n}, 32'h1);

    // Unknown opcode
    issue(operation_t'(5'd31), 32'd3, 32'd9);
    chk("unk_r", r, 32'h0);
    chk("unk_vout", {31'h0, valid_out}, 32'h1);

    // 2: MUL -3 * 4
    issue(ALU_MUL, 32'hFFFF_FFFD, 32'd4);
    chk("mul_busy_start", {31'h0, busy}, 32'h1);
    run_md(lat, bsy);
    chk("mul_lat", lat, 32'd34);
    chk("mul_busy_cycles", bsy, 32'd34);
    chk("mul_lo", lo, 32'hFFFF_FFF4);
    chk("mul_r", r, 32'hFFFF_FFF4);
    chk("mul_hi", hi, 32'hFFFF_FFFF);
    chk("mul_n", {31'h0, n}, 32'h1);
    chk("mul_busy_end", {31'h0, busy}, 32'h0);
    @(posedge clk);
    #1;

    // 3: DIV -7 / 2, then MFHI and MFLO
    issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    run_md(lat, bsy);
    chk("div_lat", lat, 32'd34);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_dz", {31'h0, dz}, 32'h0);
    @(posedge clk);
    #1;
    issue(ALU_MFHI, 32'd0, 32'd0);
    chk("mfhi_r", r, 32'hFFFF_FFFF);
    chk("mfhi_hi_kept", hi, 32'hFFFF_FFFF);
    issue(ALU_MFLO, 32'd0, 32'd0);
    chk("mflo_r", r, 32'hFFFF_FFFD);

    // Signed overflow: most-negative / -1
    issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md(lat, bsy);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);
    chk("ovf_dz", {31'h0, dz}, 32'h0);
    @(posedge clk);
    #1;

    // 4: DIVU by zero
    issue(ALU_DIVU, 32'd10, 32'd0);
    run_md(lat, bsy);
    chk("dz_lat", lat, 32'd34);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_hi", hi, 32'd10);
    chk("dz_flag", {31'h0, dz}, 32'h1);
    @(posedge clk);
    #1;

    // 5: MULU aborted by reset at iteration 10
    issue(ALU_MULU, 32'hFFFF_FFFF, 32'd2);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("abort_busy_pre", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_r", r, 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_flags", {28'h0, valid_out, z, n, dz}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(ALU_ADD, 32'd1, 32'd1);
    chk("post_rst_add", r, 32'd2);
    chk("post_rst_vout", {31'h0, valid_out}, 32'h1);

    // 6: SUB during busy MUL is dropped
    issue(ALU_MUL, 32'd6, 32'd7);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    op       = ALU_SUB;
    a        = 32'd100;
    b        = 32'd1;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    pulses   = 0;
    r_seen   = 32'h0;
    repeat (45) begin
      if (valid_out) begin
        pulses++;
        r_seen = r;
      end
      @(posedge clk);
      #1;
    end
    chk("ignore_pulses", pulses, 32'd1);
    chk("ignore_r", r_seen, 32'd42);
    chk("ignore_hi", hi, 32'd0);

    issue(ALU_SRL, 32'h21, 32'h80);
    chk("srl_r", r, 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Registered successor to the combinational ALU. Adds iterative signed/unsigned multiply and divide with HI/LO result registers and a valid/busy handshake. Single-cycle ops keep the existing operation set but return registered results. Sits in the EX stage; the pipeline stalls while busy is high.

Parameters:
DATA_SIZE, 32, operand/result width; must be even and >= 8
SHAMT_W, $clog2(DATA_SIZE), shift-amount bits taken from a

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  operation request; sampled only when busy=0
op  in  operation  opcode from shared definitions package
a  in  DATA_SIZE  signed operand A (shift amount for shifts)
b  in  DATA_SIZE  signed operand B
busy  out  1  high while an iterative op is in flight
valid_out  out  1  one-cycle pulse; r/z/n/dz valid this cycle
r  out  DATA_SIZE  result; for MUL/DIV equals new LO
hi  out  DATA_SIZE  HI register, always visible
lo  out  DATA_SIZE  LO register, always visible
z  out  1  r==0
n  out  1  r[DATA_SIZE-1]
dz  out  1  divide-by-zero flag, valid with valid_out

Behaviour:
- Reset (async, rst_n=0): state IDLE; r, hi, lo, z, n, dz, busy, valid_out all 0; iteration counter 0. Takes effect immediately, including mid-operation; the partial result is discarded.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE, valid_in=1, basic op (ADD SUB AND OR XOR SLL SRL SLA SRA LUI LLI NOT): at the next edge r gets the result and valid_out=1 (latency 1), then state stays IDLE. Shifts use a[SHAMT_W-1:0] only. An unknown opcode gives r=0 and valid_out=1.
- MFHI/MFLO: r=hi or r=lo, latency 1. hi and lo are unchanged.
- MUL/MULU: latch operands; signed MUL uses magnitudes plus a sign bit. Then go to MUL and run DATA_SIZE radix-2 shift-add iterations, one per cycle.
- DIV/DIVU: same latching, then go to DIV and run DATA_SIZE restoring-division iterations.
- FIX (1 cycle): apply the sign fix.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the sign of a.
- DONE (1 cycle): write {hi,lo}, set r=lo, valid_out=1, then return to IDLE.
- Total latency for MUL/DIV: valid_out rises DATA_SIZE+2 cycles after the accept edge.
- busy is high from the cycle after the accept through DONE inclusive. valid_in while busy is ignored, not queued.
- Divide by zero: skip the iterations; in FIX set lo=all ones, hi=a, dz=1. Same latency.
- Signed DIV of most-negative by -1: lo=most-negative, hi=0, dz=0; no trap.
- MULU/DIVU treat operands as unsigned; no sign fix.
- z and n are computed from the value registered into r. They update only when valid_out fires and hold otherwise.

Decomposition:
- Shared package definitions: extend the operation enum with ALU_MUL, ALU_MULU, ALU_DIV, ALU_DIVU, ALU_MFHI, ALU_MFLO. Add an md_state_t enum for the states.
- Sub-module muldiv_core: holds the iteration datapath and counter, with start/done ports. alu_muldiv keeps the basic-op mux, handshake and HI/LO registers.

Test Plan:
1. ADD, a=5, b=7, valid_in pulse -> next cycle r=12, valid_out=1, z=0, n=0, busy stays 0.
2. MUL, a=-3, b=4 -> busy for 34 cycles; then valid_out with lo=r=0xFFFFFFF4, hi=0xFFFFFFFF, n=1.
3. DIV, a=-7, b=2 -> after 34 cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), dz=0. Follow with MFHI -> r=0xFFFFFFFF next cycle.
4. DIVU, a=10, b=0 -> after 34 cycles lo=0xFFFFFFFF, hi=10, dz=1.
5. MULU, a=0xFFFFFFFF, b=2. Assert rst_n=0 at iteration 10 -> all outputs 0 immediately, state IDLE. After release, ADD 1+1 -> r=2.
6. During a busy MUL, pulse valid_in with SUB -> ignored, only one valid_out pulse. Then SRL with a=0x21, b=0x80 -> r=0x40 (shift uses a[4:0]=1).
